apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Shares one APB slave port between NREQ local requesters with round-robin arbitration. Sequences each granted request through the APB IDLE/SETUP/ACCESS phases and honours slave wait states via PREADY. Returns read data and completion status to the winning requester. Sits between the on-chip request sources and the byte-strobed memory slaves on the same PCLK domain.

## Interface
- NREQ, 2, number of requesters (2..8)
- ADDWIDTH, 8, APB address width
- DATAWIDTH, 32, APB data width (multiple of 8)
- TIMEOUT, 15, max PREADY-low ACCESS cycles before abort (only with APB_TIMEOUT_EN)

Ports:
- PCLK  in  1  single clock; all logic on posedge
- PRESETn  in  1  reset: synchronous and active-low
- req_valid  in  NREQ  request pending, one bit per requester; held until its req_ack
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDWIDTH  packed addresses; requester i at [i*ADDWIDTH +: ADDWIDTH]
- req_wdata  in  NREQ*DATAWIDTH  packed write data
- req_strb  in  NREQ*(DATAWIDTH/8)  packed byte strobes
- req_ack  out  NREQ  one-cycle completion pulse to the served requester
- rsp_rdata  out  DATAWIDTH  read data; valid in the req_ack cycle
- rsp_err  out  1  timeout abort flag; valid in the req_ack cycle
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDWIDTH; PWDATA  out  DATAWIDTH; PSTRB  out  DATAWIDTH/8
- PREADY  in  1  slave ready
- PRDATA  in  DATAWIDTH  slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE
  - Eligible = req_valid & ~req_ack.
  - The ~req_ack mask prevents re-granting a requester in its own ack cycle.
  - If any requester is eligible, select the first one at or after the priority pointer, wrapping modulo NREQ.
  - Register its write, address, wdata and strb onto PWRITE/PADDR/PWDATA/PSTRB.
  - Move to SETUP.
- SETUP
  - PSEL=1, PENABLE=0.
  - Move to ACCESS unconditionally.
- ACCESS
  - PSEL=1, PENABLE=1.
  - Stay in ACCESS while PREADY=0.
  - On the posedge with PREADY=1, go to IDLE and complete the transfer:
    - req_ack[g]=1 for one cycle.
    - rsp_rdata <= PRDATA on reads, 0 on writes.
    - rsp_err=0.
- Round-robin: after granting g, the pointer becomes (g+1) mod NREQ. A continuously requesting source cannot starve the others.
- PADDR/PWRITE/PWDATA/PSTRB stay stable from SETUP through the end of ACCESS. They hold their last value in IDLE.
- PRESETn=0 at any posedge, including mid-transfer:
  - FSM goes to IDLE, pointer to 0.
  - All outputs go to 0.
  - The aborted transfer is never acked.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, req_ack, rsp_rdata and rsp_err are all 0.
- Request eligible in cycle t (IDLE): SETUP in t+1, ACCESS from t+2.
- With PREADY=1 at the first ACCESS posedge, req_ack is high in t+3.
- Each slave wait cycle adds one cycle.
- Minimum spacing between APB transfers: one IDLE cycle, which coincides with the req_ack cycle. Back-to-back throughput is one transfer per 3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Requesters change req_* fields only in or after their req_ack cycle.

## Configuration
- APB_TIMEOUT_EN defined
  - A counter clears on entry to ACCESS and increments on each ACCESS posedge with PREADY=0.
  - When the count reaches TIMEOUT, the FSM goes to IDLE and the transfer completes with req_ack[g]=1, rsp_err=1, rsp_rdata=0.
  - PSEL and PENABLE deassert on that same posedge.
- APB_TIMEOUT_EN undefined
  - No counter; ACCESS waits indefinitely for PREADY.
  - rsp_err is tied to 0.

## Test plan
- Reset: hold PRESETn=0 for 3 cycles with req_valid=2'b11 -> all outputs 0, no PSEL.
- Write then read:
  - Requester 0 writes addr 0x10, data 0xDEADBEEF, strb 4'hF. Slave inserts 4 wait cycles -> PSEL in t+1, PENABLE in t+2, req_ack[0] in t+7.
  - Read of 0x10 -> rsp_rdata=0xDEADBEEF in the ack cycle.
- Simultaneous requests: req_valid=2'b11 after reset -> requester 0 served first, then 1. Both stay asserted -> grants alternate 0,1,0,1; no re-grant in a requester's ack cycle.
- Partial strobe: write 0x11223344 with strb 4'b0101 over 0xFFFFFFFF at addr 0x20 -> readback 0xFF22FF44.
- Timeout (APB_TIMEOUT_EN, TIMEOUT=15): PREADY held 0 -> req_ack with rsp_err=1 and rsp_rdata=0 after 15 ACCESS cycles, then PSEL=0.
- Reset mid-ACCESS: PRESETn=0 for one cycle during wait states -> PSEL=0 next cycle, no req_ack; re-request is served normally.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: shares one APB slave port between NREQ requesters using
// round-robin arbitration, runs each grant through SETUP/ACCESS and returns
// read data plus completion status to the winner.
// Optional feature macro: APB_TIMEOUT_EN. When defined, an ACCESS phase that
// sees PREADY low for TIMEOUT cycles is aborted and completes with rsp_err=1.
// When undefined, ACCESS waits indefinitely and rsp_err is tied to 0.
module apb_master_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ADDWIDTH  = 8,
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                            PCLK,
  input  logic                            PRESETn,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ-1:0]                 req_write,
  input  logic [NREQ*ADDWIDTH-1:0]        req_addr,
  input  logic [NREQ*DATAWIDTH-1:0]       req_wdata,
  input  logic [NREQ*(DATAWIDTH/8)-1:0]   req_strb,
  output logic [NREQ-1:0]                 req_ack,
  output logic [DATAWIDTH-1:0]            rsp_rdata,
  output logic                            rsp_err,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [ADDWIDTH-1:0]             PADDR,
  output logic [DATAWIDTH-1:0]            PWDATA,
  output logic [DATAWIDTH/8-1:0]          PSTRB,
  input  logic                            PREADY,
  input  logic [DATAWIDTH-1:0]            PRDATA
);

  localparam int unsigned STRBW = DATAWIDTH / 8;
  localparam int unsigned PTRW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Reject parameter sets the datapath is not built for
  if (NREQ < 2 || NREQ > 8 || (DATAWIDTH % 8) != 0 || TIMEOUT == 0) begin : g_bad_params
    $error("apb_master_arbiter: unsupported parameter set");
  end

  state_t            state;
  logic [PTRW-1:0]   ptr;
  logic [PTRW-1:0]   gnt;
  logic [NREQ-1:0]   elig;
  logic              found;
  logic [PTRW-1:0]   sel;
  logic [PTRW-1:0]   idx;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0]    wait_cnt;
`endif

  // Round-robin pick: first eligible requester at or after the pointer; the
  // req_ack mask keeps a requester from being re-granted in its own ack cycle
  always_comb begin
    elig  = req_valid & ~req_ack;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = PTRW'((32'(ptr) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // APB sequencer with registered bus and response outputs
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      req_ack   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      req_ack <= '0;
      rsp_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= sel;
            ptr     <= PTRW'((32'(sel) + 32'd1) % NREQ);
            PWRITE  <= req_write[sel];
            PADDR   <= req_addr[32'(sel)*ADDWIDTH +: ADDWIDTH];
            PWDATA  <= req_wdata[32'(sel)*DATAWIDTH +: DATAWIDTH];
            PSTRB   <= req_strb[32'(sel)*STRBW +: STRBW];
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          state    <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            state        <= IDLE;
            req_ack[gnt] <= 1'b1;
            rsp_rdata    <= PWRITE ? '0 : PRDATA;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == TOW'(TIMEOUT - 1)) begin
            // Slave stalled too long: abort and report the error to the requester
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            state        <= IDLE;
            req_ack[gnt] <= 1'b1;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b1;
            wait_cnt     <= '0;
          end else begin
            wait_cnt <= wait_cnt + TOW'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: cycle-accurate transaction-level model of the arbiter
// (grant order, phase timing, byte-strobed slave memory) checked every cycle
// against the DUT, with directed scenarios followed by randomized traffic.
module tb_apb_master_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned TO   = 15;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } txn_t;

  logic                 PCLK = 1'b0;
  logic                 PRESETn;
  logic [NREQ-1:0]      req_valid, req_write, req_ack;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ*SW-1:0]   req_strb;
  logic [DW-1:0]        rsp_rdata, PWDATA, PRDATA;
  logic                 rsp_err, PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0]        PADDR;
  logic [SW-1:0]        PSTRB;

  apb_master_arbiter #(.NREQ(NREQ), .ADDWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_ack(req_ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Byte-strobed slave memory (environment, driven only by the APB bus)
  logic [31:0] slave_mem [256];
  assign PRDATA = slave_mem[PADDR];
  always @(posedge PCLK) begin
    if (PRESETn && PSEL && PENABLE && PREADY && PWRITE)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) slave_mem[PADDR][b*8 +: 8] <= PWDATA[b*8 +: 8];
  end

  // Reference state
  logic [31:0] ref_mem [256];
  txn_t        txq [NREQ][$];
  txn_t        cur [NREQ];
  logic [NREQ-1:0] rv, ack_prev;
  int          forced_w [$];
  int          cyc, ptr, g, t0, last;
  bit          xfer, abort, post_rst, gen_random, mid_rst_arm;
  int          rst_hold;
  bit          e_write;
  logic [7:0]  e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_strb;
  int          n_vec, n_err;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got 0x%0h want 0x%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic txn_t mk(input bit wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s);
    txn_t t;
    t.wr = wr; t.addr = a; t.data = d; t.strb = s;
    return t;
  endfunction

  // One clock cycle: check outputs, update requesters, drive inputs, advance model
  task automatic step();
    logic [NREQ-1:0] e_ack, elig;
    logic [31:0]     e_rd;
    bit              e_psel, e_pen, rst_now, found;
    int              w;
    @(negedge PCLK);
    e_ack = '0;
    if (xfer && cyc == last + 1) e_ack[g] = 1'b1;
    e_psel = xfer && cyc >= t0 + 1 && cyc <= last;
    e_pen  = xfer && cyc >= t0 + 2 && cyc <= last;
    if (cyc > 0) begin
      check_eq("psel", 64'(PSEL), 64'(e_psel));
      check_eq("penable", 64'(PENABLE), 64'(e_pen));
      check_eq("req_ack", 64'(req_ack), 64'(e_ack));
      check_eq("paddr", 64'(PADDR), 64'(e_addr));
      check_eq("pwrite", 64'(PWRITE), 64'(e_write));
      check_eq("pwdata", 64'(PWDATA), 64'(e_wdata));
      check_eq("pstrb", 64'(PSTRB), 64'(e_strb));
      if (e_ack != '0) begin
        e_rd = '0;
        if (!abort && e_write) begin
          for (int b = 0; b < 4; b++)
            if (e_strb[b]) ref_mem[e_addr][b*8 +: 8] = e_wdata[b*8 +: 8];
        end else if (!abort) begin
          e_rd = ref_mem[e_addr];
        end
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
        check_eq("rsp_err", 64'(rsp_err), 64'(abort));
      end else if (post_rst) begin
        check_eq("rst_rdata", 64'(rsp_rdata), 64'd0);
        check_eq("rst_err", 64'(rsp_err), 64'd0);
      end
    end
    post_rst = 1'b0;

    // Requesters hold through their ack cycle and move on the cycle after
    for (int i = 0; i < NREQ; i++) begin
      if (!rv[i] || ack_prev[i]) begin
        if (txq[i].size() > 0) begin
          cur[i] = txq[i].pop_front();
          rv[i]  = 1'b1;
        end else if (gen_random && $urandom_range(0, 2) == 0) begin
          cur[i] = mk(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom,
                      4'($urandom_range(0, 15)));
          rv[i]  = 1'b1;
        end else begin
          rv[i] = 1'b0;
        end
      end
    end
    ack_prev = e_ack;

    rst_now = rst_hold > 0;
    if (rst_hold > 0) rst_hold--;
    if (mid_rst_arm && xfer && cyc == t0 + 4) begin
      rst_now     = 1'b1;
      mid_rst_arm = 1'b0;
    end
    if (gen_random && $urandom_range(0, 299) == 0) rst_now = 1'b1;

    PRESETn = !rst_now;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = rv[i];
      req_write[i]          = cur[i].wr;
      req_addr[i*AW +: AW]  = cur[i].addr;
      req_wdata[i*DW +: DW] = cur[i].data;
      req_strb[i*SW +: SW]  = cur[i].strb;
    end
    if (xfer && cyc >= t0 + 2 && cyc <= last)
      PREADY = !abort && cyc == last;
    else
      PREADY = 1'($urandom_range(0, 1));

    if (rst_now) begin
      xfer = 1'b0; ptr = 0;
      e_write = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
      post_rst = 1'b1;
    end else if (!(xfer && cyc <= last)) begin
      xfer  = 1'b0;
      elig  = rv & ~e_ack;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        int idx = (ptr + k) % NREQ;
        if (!found && elig[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      if (found) begin
        w       = (forced_w.size() > 0) ? forced_w.pop_front() : int'($urandom_range(0, 3));
        t0      = cyc;
        abort   = TO_EN && w >= int'(TO);
        last    = abort ? t0 + 1 + int'(TO) : t0 + 2 + w;
        ptr     = (g + 1) % NREQ;
        e_write = cur[g].wr;
        e_addr  = cur[g].addr;
        e_wdata = cur[g].data;
        e_strb  = cur[g].strb;
        xfer    = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic drain(input string tag);
    bit busy;
    busy = 1'b1;
    for (int k = 0; k < 600 && busy; k++) begin
      step();
      busy = xfer || rv != '0 || ack_prev != '0;
      for (int i = 0; i < NREQ; i++) if (txq[i].size() > 0) busy = 1'b1;
    end
    check_eq({tag, "_drain"}, 64'(busy), 64'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; ptr = 0; g = 0; t0 = 0; last = 0;
    xfer = 1'b0; abort = 1'b0; post_rst = 1'b0; gen_random = 1'b0; mid_rst_arm = 1'b0;
    e_write = 1'b0; e_addr = '0; e_wdata = '0; e_strb = '0;
    rv = '0; ack_prev = '0;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = '0;
      slave_mem[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) cur[i] = mk(1'b0, 8'h0, 32'h0, 4'h0);
    PRESETn = 1'b0; PREADY = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_strb = '0;

    // Reset with both requesters pending, then alternating service 0,1,0,1,1:
    // write/read 0x10 with 4 wait states, partial-strobe write over 0x20
    txq[0].push_back(mk(1'b1, 8'h10, 32'hDEADBEEF, 4'hF));
    txq[0].push_back(mk(1'b0, 8'h10, 32'h0, 4'h0));
    txq[1].push_back(mk(1'b1, 8'h20, 32'hFFFFFFFF, 4'hF));
    txq[1].push_back(mk(1'b1, 8'h20, 32'h11223344, 4'b0101));
    txq[1].push_back(mk(1'b0, 8'h20, 32'h0, 4'h0));
    forced_w.push_back(4);
    rst_hold = 3;
    drain("basic");

    // Reset during ACCESS wait states; the request is then served again
    mid_rst_arm = 1'b1;
    forced_w.push_back(8);
    txq[1].push_back(mk(1'b0, 8'h10, 32'h0, 4'h0));
    drain("midrst");

    // Long PREADY stall (aborts when the timeout feature is built in)
    forced_w.push_back(20);
    txq[0].push_back(mk(1'b1, 8'h30, 32'h12345678, 4'hF));
    txq[0].push_back(mk(1'b0, 8'h30, 32'h0, 4'h0));
    drain("stall");

    // Randomized traffic with occasional resets
    gen_random = 1'b1;
    repeat (3000) step();
    gen_random = 1'b0;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
